regfile_mp: RTL and testbench

Parametrised multi-port register file for the next-generation CPU datapath: configurable data width, depth, read-port count and two write ports. It adds same-cycle write-to-read bypass and a per-register pending-write scoreboard, so the hazard unit can stall on in-flight producers. Register 0 is hardwired to zero and never pending. It sits between decode (reads, reservations) and writeback (writes, releases).

---
 rtl/regfile_pkg.sv | 28 ++
 rtl/regfile_scoreboard.sv | 33 +++
 rtl/regfile_mp.sv | 76 +++++++
 tb/tb_regfile_mp.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, types and the write-port match helper for the multi-port register file.
package regfile_pkg;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned NR_MAX   = 4;
  localparam int unsigned NWP      = 2;
  localparam int unsigned AW_MAX   = 16;

  typedef enum logic {
    WP_OLD   = 1'b0,
    WP_YOUNG = 1'b1
  } wport_e;

  // Per-write-port match against a read address; address 0 never matches.
  // Addresses are zero-extended to AW_MAX so one helper serves every depth.
  function automatic logic [NWP-1:0] wr_hit(
    input logic [AW_MAX-1:0]     addr,
    input logic [NWP-1:0]        we,
    input logic [NWP*AW_MAX-1:0] waddr
  );
    logic [NWP-1:0] hit;
    hit    = '0;
    hit[0] = we[0] && (waddr[AW_MAX-1:0] == addr) && (addr != AW_MAX'(REG_ZERO));
    hit[1] = we[1] && (waddr[2*AW_MAX-1:AW_MAX] == addr) && (addr != AW_MAX'(REG_ZERO));
    return hit;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, reservation beats release on the same edge.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int unsigned DEPTH = 32,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NWP-1:0]      we,
  input  logic [NWP*AW-1:0]   waddr,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic [DEPTH-1:0]    pend
);

  logic [DEPTH-1:0] pend_next;

  // Clears first, then the set, so a new producer supersedes a retiring one.
  always_comb begin
    pend_next = pend;
    if (we[0]) pend_next[waddr[AW-1:0]] = 1'b0;
    if (we[1]) pend_next[waddr[2*AW-1:AW]] = 1'b0;
    if (rsv_en) pend_next[rsv_addr] = 1'b1;
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= pend_next;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, NR read ports, optional write bypass, pending scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int unsigned DW     = 32,
  parameter  int unsigned DEPTH  = 32,
  parameter  int unsigned NR     = 2,
  parameter  bit          BYPASS = 1'b1,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NWP-1:0]     we,
  input  logic [NWP*AW-1:0]  waddr,
  input  logic [NWP*DW-1:0]  wdata,
  input  logic [NR*AW-1:0]   raddr,
  output logic [NR*DW-1:0]   rdata,
  output logic [NR-1:0]      rbusy,
  input  logic               rsv_en,
  input  logic [AW-1:0]      rsv_addr,
  output logic [DEPTH-1:0]   pend
);

  logic [AW-1:0]           wa0, wa1;
  logic [DW-1:0]           wd0, wd1;
  logic [NWP*AW_MAX-1:0]   waddr_ext;
  logic [DW-1:0]           mem [DEPTH];

  assign wa0       = waddr[AW-1:0];
  assign wa1       = waddr[2*AW-1:AW];
  assign wd0       = wdata[DW-1:0];
  assign wd1       = wdata[2*DW-1:DW];
  assign waddr_ext = {AW_MAX'(wa1), AW_MAX'(wa0)};

  regfile_scoreboard #(
    .DEPTH (DEPTH)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (waddr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .pend     (pend)
  );

  // Port 1 is written last so it wins a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (we[0] && (wa0 != AW'(REG_ZERO))) mem[wa0] <= wd0;
      if (we[1] && (wa1 != AW'(REG_ZERO))) mem[wa1] <= wd1;
    end
  end

  for (genvar r = 0; r < NR; r++) begin : g_rd
    logic [AW-1:0]  ra;
    logic [NWP-1:0] hit;
    logic [DW-1:0]  rd;

    assign ra  = raddr[r*AW +: AW];
    assign hit = BYPASS ? wr_hit(AW_MAX'(ra), we, waddr_ext) : '0;

    always_comb begin
      rd = (ra == AW'(REG_ZERO)) ? '0 : mem[ra];
      if (hit[WP_YOUNG])    rd = wd1;
      else if (hit[WP_OLD]) rd = wd0;
      if (!rst_n)           rd = '0;
    end

    assign rdata[r*DW +: DW] = rd;
    assign rbusy[r]          = rst_n & pend[ra] & ~(|hit);
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: three builds (bypass, no bypass, 4-port/16-deep) against an array model.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the two default-geometry builds
  logic [1:0]  we = '0;
  logic [9:0]  waddr = '0;
  logic [63:0] wdata = '0;
  logic [9:0]  raddr = '0;
  logic        rsv_en = 1'b0;
  logic [4:0]  rsv_addr = '0;
  logic [63:0] rdata_a, rdata_b;
  logic [1:0]  rbusy_a, rbusy_b;
  logic [31:0] pend_a, pend_b;

  // Stimulus for the 4-port, 16-deep, 16-bit build
  logic [1:0]  we_c = '0;
  logic [7:0]  waddr_c = '0;
  logic [31:0] wdata_c = '0;
  logic [15:0] raddr_c = '0;
  logic        rsv_en_c = 1'b0;
  logic [3:0]  rsv_addr_c = '0;
  logic [63:0] rdata_c;
  logic [3:0]  rbusy_c;
  logic [15:0] pend_c;

  regfile_mp #(.BYPASS(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata_a), .rbusy(rbusy_a), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pend(pend_a));

  regfile_mp #(.BYPASS(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata_b), .rbusy(rbusy_b), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pend(pend_b));

  regfile_mp #(.DW(16), .DEPTH(16), .NR(4), .BYPASS(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .we(we_c), .waddr(waddr_c), .wdata(wdata_c), .raddr(raddr_c),
    .rdata(rdata_c), .rbusy(rbusy_c), .rsv_en(rsv_en_c), .rsv_addr(rsv_addr_c), .pend(pend_c));

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mm [32];
  logic [31:0] mp;
  logic [15:0] mc [16];
  logic [15:0] pc;

  initial begin
    for (int i = 0; i < 32; i++) mm[i] = '0;
    for (int i = 0; i < 16; i++) mc[i] = '0;
    mp = '0;
    pc = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < 32; i++) mm[i] = '0;
        for (int i = 0; i < 16; i++) mc[i] = '0;
        mp = '0;
        pc = '0;
      end else begin
        // writes applied oldest-first so the younger port ends up stored
        for (int p = 0; p < 2; p++) begin
          if (we[p] && waddr[p*5 +: 5] != 0) mm[waddr[p*5 +: 5]] = wdata[p*32 +: 32];
          if (we_c[p] && waddr_c[p*4 +: 4] != 0) mc[waddr_c[p*4 +: 4]] = wdata_c[p*16 +: 16];
        end
        for (int p = 0; p < 2; p++) begin
          if (we[p]) mp[waddr[p*5 +: 5]] = 1'b0;
          if (we_c[p]) pc[waddr_c[p*4 +: 4]] = 1'b0;
        end
        if (rsv_en)   mp[rsv_addr]   = 1'b1;
        if (rsv_en_c) pc[rsv_addr_c] = 1'b1;
        mp[0] = 1'b0;
        pc[0] = 1'b0;
      end
    end
  end

  function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] a);
    if (!rst_n || a == 0) return '0;
    if (byp && we[1] && waddr[9:5] == a) return wdata[63:32];
    if (byp && we[0] && waddr[4:0] == a) return wdata[31:0];
    return mm[a];
  endfunction

  function automatic logic exp_busy(input bit byp, input logic [4:0] a);
    logic written;
    written = (we[1] && waddr[9:5] == a) || (we[0] && waddr[4:0] == a);
    return rst_n && mp[a] && !(byp && written);
  endfunction

  function automatic logic [15:0] exp_rd_c(input logic [3:0] a);
    if (!rst_n || a == 0) return '0;
    if (we_c[1] && waddr_c[7:4] == a) return wdata_c[31:16];
    if (we_c[0] && waddr_c[3:0] == a) return wdata_c[15:0];
    return mc[a];
  endfunction

  function automatic logic exp_busy_c(input logic [3:0] a);
    logic written;
    written = (we_c[1] && waddr_c[7:4] == a) || (we_c[0] && waddr_c[3:0] == a);
    return rst_n && pc[a] && !written;
  endfunction

  bit chk_en = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int r = 0; r < 2; r++) begin
          check("cmp_rdata_a", rdata_a[r*32 +: 32], exp_rd(1'b1, raddr[r*5 +: 5]));
          check("cmp_rdata_b", rdata_b[r*32 +: 32], exp_rd(1'b0, raddr[r*5 +: 5]));
          check("cmp_rbusy_a", rbusy_a[r], exp_busy(1'b1, raddr[r*5 +: 5]));
          check("cmp_rbusy_b", rbusy_b[r], exp_busy(1'b0, raddr[r*5 +: 5]));
        end
        for (int r = 0; r < 4; r++) begin
          check("cmp_rdata_c", rdata_c[r*16 +: 16], exp_rd_c(raddr_c[r*4 +: 4]));
          check("cmp_rbusy_c", rbusy_c[r], exp_busy_c(raddr_c[r*4 +: 4]));
        end
        check("cmp_pend_a", pend_a, mp);
        check("cmp_pend_b", pend_b, mp);
        check("cmp_pend_c", pend_c, pc);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = '0; rsv_en = 1'b0; we_c = '0; rsv_en_c = 1'b0;
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    we[p] = 1'b1;
    waddr[p*5 +: 5] = a;
    wdata[p*32 +: 32] = d;
  endtask

  task automatic wr_c(input int p, input logic [3:0] a, input logic [15:0] d);
    we_c[p] = 1'b1;
    waddr_c[p*4 +: 4] = a;
    wdata_c[p*16 +: 16] = d;
  endtask

  initial begin
    chk_en = 1'b1;
    cycle(); cycle();
    check("reset_rdata_a", rdata_a, 64'h0);
    check("reset_pend_a", pend_a, 32'h0);
    check("reset_rbusy_a", rbusy_a, 2'b00);
    rst_n = 1'b1;
    cycle();

    // write r5 on port 0, read it back on read port 0
    wr(0, 5'd5, 32'hDEAD_BEEF);
    raddr[4:0] = 5'd5;
    #2;
    check("bypass_same_cycle", rdata_a[31:0], 32'hDEAD_BEEF);
    check("nobypass_old_value", rdata_b[31:0], 32'h0);
    cycle(); idle(); #2;
    check("bypass_next_cycle", rdata_a[31:0], 32'hDEAD_BEEF);
    check("nobypass_next_cycle", rdata_b[31:0], 32'hDEAD_BEEF);

    // register 0 ignores writes and reservations
    wr(0, 5'd0, 32'h1234);
    raddr[4:0] = 5'd0;
    #2;
    check("r0_same_cycle", rdata_a[31:0], 32'h0);
    cycle(); idle();
    rsv_en = 1'b1; rsv_addr = 5'd0;
    #2;
    check("r0_next_cycle", rdata_b[31:0], 32'h0);
    cycle(); idle(); #2;
    check("r0_never_pending", pend_a[0], 1'b0);

    // collision on r7: port 1 wins in storage and bypass
    wr(0, 5'd7, 32'hAAAA);
    wr(1, 5'd7, 32'h5555);
    raddr[9:5] = 5'd7;
    #2;
    check("collision_bypass", rdata_a[63:32], 32'h5555);
    cycle(); idle(); #2;
    check("collision_stored", rdata_b[63:32], 32'h5555);

    // reserve r9, then release it with a write
    rsv_en = 1'b1; rsv_addr = 5'd9;
    raddr[4:0] = 5'd9;
    #2;
    check("busy_not_before_edge", rbusy_a[0], 1'b0);
    cycle(); idle(); #2;
    check("busy_after_reserve", rbusy_a[0], 1'b1);
    wr(0, 5'd9, 32'h42);
    #1;
    check("release_bypass_data", rdata_a[31:0], 32'h42);
    check("release_bypass_busy", rbusy_a[0], 1'b0);
    check("release_nobypass_busy", rbusy_b[0], 1'b1);
    cycle(); idle(); #2;
    check("release_pend_clear", pend_a[9], 1'b0);
    check("release_nobypass_next", rbusy_b[0], 1'b0);
    check("release_nobypass_data", rdata_b[31:0], 32'h42);

    // reserve and write r9 on the same edge: the reservation survives
    rsv_en = 1'b1; rsv_addr = 5'd9;
    wr(1, 5'd9, 32'h77);
    cycle(); idle(); #2;
    check("set_beats_clear", pend_a[9], 1'b1);
    check("set_beats_clear_busy", rbusy_a[0], 1'b1);

    // 4-port build: r1..r4 written two per cycle, read on four ports
    wr_c(0, 4'd1, 16'h11); wr_c(1, 4'd2, 16'h22);
    cycle(); idle();
    wr_c(0, 4'd3, 16'h33); wr_c(1, 4'd4, 16'h44);
    cycle(); idle();
    raddr_c = {4'd4, 4'd3, 4'd2, 4'd1};
    rsv_en_c = 1'b1; rsv_addr_c = 4'd3;
    #2;
    check("c_port0", rdata_c[15:0],  16'h11);
    check("c_port1", rdata_c[31:16], 16'h22);
    check("c_port2", rdata_c[47:32], 16'h33);
    check("c_port3", rdata_c[63:48], 16'h44);
    cycle(); idle(); #2;
    check("c_busy_r3", rbusy_c, 4'b0100);

    // asynchronous reset in mid-cycle clears outputs before any edge
    raddr = {5'd9, 5'd7};
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rdata_a", rdata_a, 64'h0);
    check("async_rbusy_a", rbusy_a, 2'b00);
    check("async_pend_a", pend_a, 32'h0);
    check("async_rdata_c", rdata_c, 64'h0);
    check("async_rbusy_c", rbusy_c, 4'b0000);
    check("async_pend_c", pend_c, 16'h0);
    cycle(); cycle();
    rst_n = 1'b1;
    #2;
    check("post_reset_r7", rdata_b[31:0], 32'h0);
    check("post_reset_r9", rdata_a[63:32], 32'h0);
    cycle(); cycle();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
